// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit format and default buffer depths.
package noc_pkg;

  localparam int FLIT_W         = 16;
  localparam int DEF_TX_CREDITS = 4;
  localparam int DEF_RX_DEPTH   = 4;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/noc_local_ni_if.sv
// Link between the local NI and its router's local port.
// The inj_* signals carry flits from the NI into the router.
// The ej_* signals carry flits from the router back into the NI.
// Each *_credit wire returns slots to the sender of that direction.
interface noc_local_ni_if import noc_pkg::*; ;

  flit_t inj_flit;
  logic  inj_valid;
  logic  inj_credit;
  flit_t ej_flit;
  logic  ej_valid;
  logic  ej_credit;

  modport master (
    output inj_flit, inj_valid, ej_credit,
    input  inj_credit, ej_flit, ej_valid
  );

  modport slave (
    input  inj_flit, inj_valid, ej_credit,
    output inj_credit, ej_flit, ej_valid
  );

endinterface

// File: rtl/noc_sync_fifo.sv
// First-word-fall-through FIFO with an occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module noc_sync_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Occupancy moves by one on push-only or pop-only, holds otherwise.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Pointers and count; wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the count decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/noc_local_ni.sv
// Local-node network interface: credit-based injection into the router
// and a buffered eject path that returns one credit per consumed flit.
module noc_local_ni import noc_pkg::*; #(
  parameter  int TX_CREDITS = DEF_TX_CREDITS,
  parameter  int RX_DEPTH   = DEF_RX_DEPTH,
  localparam int CW         = $clog2(TX_CREDITS + 1),
  localparam int RCW        = $clog2(RX_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_local_ni_if.master        link,
  input  flit_t                 tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output flit_t                 rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  credit_err_o,
  output logic                  rx_ovf_o
);

  logic [CW-1:0]  credit_cnt_q, credit_cnt_d;
  logic           credit_err_q, credit_err_d;
  flit_t          flit_q;
  logic           valid_q;
  logic           credit_incr_q;
  logic           rx_ovf_q;
  logic           send, rx_pop, rx_full, rx_empty;
  logic [RCW-1:0] rx_count;

  assign tx_ready_o = (credit_cnt_q != '0);
  assign send       = tx_valid_i && tx_ready_o;
  assign rx_valid_o = !rx_empty;
  assign rx_pop     = rx_valid_o && rx_ready_i;

  assign link.inj_flit  = flit_q;
  assign link.inj_valid = valid_q;
  assign link.ej_credit = credit_incr_q;
  assign credit_err_o   = credit_err_q;
  assign rx_ovf_o       = rx_ovf_q;

  // A send and a returned credit in the same cycle cancel out; a return at
  // the full count means the router sent more credits than slots exist.
  always_comb begin
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    if (send && !link.inj_credit) begin
      credit_cnt_d = credit_cnt_q - 1'b1;
    end else if (link.inj_credit && !send) begin
      if (credit_cnt_q == CW'(TX_CREDITS)) credit_err_d = 1'b1;
      else credit_cnt_d = credit_cnt_q + 1'b1;
    end
  end

  // Transmit register, credit counter, credit return pulse and sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt_q  <= CW'(TX_CREDITS);
      credit_err_q  <= 1'b0;
      flit_q        <= '0;
      valid_q       <= 1'b0;
      credit_incr_q <= 1'b0;
      rx_ovf_q      <= 1'b0;
    end else begin
      credit_cnt_q  <= credit_cnt_d;
      credit_err_q  <= credit_err_d;
      valid_q       <= send;
      if (send) flit_q <= tx_data_i;
      credit_incr_q <= rx_pop;
      if (link.ej_valid && rx_full && !rx_pop) rx_ovf_q <= 1'b1;
    end
  end

  noc_sync_fifo #(.W(FLIT_W), .DEPTH(RX_DEPTH)) u_eject_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (link.ej_valid),
    .data_i  (link.ej_flit),
    .pop_i   (rx_ready_i),
    .data_o  (rx_data_o),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  // The eject buffer can never report more flits than it holds.
  rx_count_bound: assert property (@(posedge clk) disable iff (rst)
    int'(rx_count) <= RX_DEPTH);

endmodule

// File: tb/tb_noc_local_ni.sv
// Directed bench for noc_local_ni; the bench plays both the core and the router.
module tb_noc_local_ni;
  import noc_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  flit_t txData;
  logic  txValid;
  logic  txReady;
  flit_t rxData;
  logic  rxValid;
  logic  rxReady;
  logic  creditErr;
  logic  rxOvf;
  int    checks = 0;
  int    errors = 0;

  noc_local_ni_if link();

  noc_local_ni #(.TX_CREDITS(4), .RX_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .link         (link.master),
    .tx_data_i    (txData),
    .tx_valid_i   (txValid),
    .tx_ready_o   (txReady),
    .rx_data_o    (rxData),
    .rx_valid_o   (rxValid),
    .rx_ready_i   (rxReady),
    .credit_err_o (creditErr),
    .rx_ovf_o     (rxOvf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then step to just after the next rising edge.
  task automatic applyStimulus(input logic tv, input flit_t td, input logic cr,
                               input logic ev, input flit_t ef, input logic rr);
    txValid         = tv;
    txData          = td;
    link.inj_credit = cr;
    link.ej_valid   = ev;
    link.ej_flit    = ef;
    rxReady         = rr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    txValid = 1'b0; txData = '0; rxReady = 1'b0;
    link.inj_credit = 1'b0; link.ej_valid = 1'b0; link.ej_flit = '0;
    #12;
    checkOutput("rst_tx_ready", 32'(txReady), 32'd1);
    checkOutput("rst_valid_o", 32'(link.inj_valid), 32'd0);
    checkOutput("rst_flit_o", 32'(link.inj_flit), 32'h0);
    checkOutput("rst_credit_o", 32'(link.ej_credit), 32'd0);
    checkOutput("rst_rx_valid", 32'(rxValid), 32'd0);
    checkOutput("rst_errs", {30'd0, creditErr, rxOvf}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Four back-to-back sends exhaust the credits.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, flit_t'(16'h1111 * (k + 1)), 1'b0, 1'b0, '0, 1'b0);
      checkOutput("tx_valid_strobe", 32'(link.inj_valid), 32'd1);
      checkOutput("tx_flit", 32'(link.inj_flit), 32'(16'h1111 * (k + 1)));
    end
    checkOutput("tx_ready_exhausted", 32'(txReady), 32'd0);
    applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("tx_held_valid", 32'(link.inj_valid), 32'd0);
    checkOutput("tx_held_flit", 32'(link.inj_flit), 32'h4444);
    applyStimulus(1'b1, 16'h5555, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("credit_ready", 32'(txReady), 32'd1);
    applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("fifth_valid", 32'(link.inj_valid), 32'd1);
    checkOutput("fifth_flit", 32'(link.inj_flit), 32'h5555);
    checkOutput("fifth_ready", 32'(txReady), 32'd0);

    // Count to 2, then send and return a credit together: count stays 2.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 16'h6666, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("both_valid", 32'(link.inj_valid), 32'd1);
    checkOutput("both_ready", 32'(txReady), 32'd1);
    applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("both_cnt1_ready", 32'(txReady), 32'd1);
    applyStimulus(1'b1, 16'h8888, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("both_cnt0_ready", 32'(txReady), 32'd0);

    // Refill to 4, then an extra credit sets the sticky error.
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("refill_no_err", 32'(creditErr), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("credit_err_set", 32'(creditErr), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("credit_err_sticky", 32'(creditErr), 32'd1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 16'h9000, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("cap4_valid", 32'(link.inj_valid), 32'd1);
    end
    checkOutput("cap4_ready", 32'(txReady), 32'd0);

    // Empty buffer with push and ready together: no bypass.
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 16'hC001, 1'b1);
    checkOutput("nobypass_valid", 32'(rxValid), 32'd1);
    checkOutput("nobypass_data", 32'(rxData), 32'hC001);
    checkOutput("nobypass_credit", 32'(link.ej_credit), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("nobypass_pop_credit", 32'(link.ej_credit), 32'd1);
    checkOutput("nobypass_empty", 32'(rxValid), 32'd0);

    // Full buffer with push and pop together: both happen, no overflow.
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b0, '0, 1'b0, 1'b1, flit_t'(16'hB001 + k), 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 16'hB005, 1'b1);
    checkOutput("fullpp_ovf", 32'(rxOvf), 32'd0);
    checkOutput("fullpp_credit", 32'(link.ej_credit), 32'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("fullpp_head", 32'(rxData), 32'(16'hB002 + k));
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      checkOutput("fullpp_pulse", 32'(link.ej_credit), 32'd1);
    end
    checkOutput("fullpp_drained", 32'(rxValid), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("fullpp_no_pulse", 32'(link.ej_credit), 32'd0);

    // Fill without popping, then overflow and drain in order.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, flit_t'(16'hA001 + k), 1'b0);
      checkOutput("fill_head", 32'(rxData), 32'hA001);
      checkOutput("fill_no_credit", 32'(link.ej_credit), 32'd0);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 16'hA005, 1'b0);
    checkOutput("ovf_set", 32'(rxOvf), 32'd1);
    checkOutput("ovf_no_credit", 32'(link.ej_credit), 32'd0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("drain_head", 32'(rxData), 32'(16'hA001 + k));
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      checkOutput("drain_pulse", 32'(link.ej_credit), 32'd1);
    end
    checkOutput("drain_empty", 32'(rxValid), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("drain_pulse_end", 32'(link.ej_credit), 32'd0);
    checkOutput("ovf_sticky", 32'(rxOvf), 32'd1);

    // Reset mid-traffic with count=1 and two flits buffered.
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 16'hD001, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 16'hD002, 1'b0);
    checkOutput("pre_rst_valid", 32'(rxValid), 32'd1);
    txValid = 1'b1; rxReady = 1'b1; link.ej_valid = 1'b0;
    rst = 1'b1;
    #2;
    checkOutput("async_rst_rx_valid", 32'(rxValid), 32'd0);
    checkOutput("async_rst_ready", 32'(txReady), 32'd1);
    checkOutput("async_rst_errs", {30'd0, creditErr, rxOvf}, 32'd0);
    @(posedge clk); #1;
    txValid = 1'b0; rxReady = 1'b0;
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("post_rst_valid_o", 32'(link.inj_valid), 32'd0);
    checkOutput("post_rst_credit_o", 32'(link.ej_credit), 32'd0);
    checkOutput("post_rst_rx_valid", 32'(rxValid), 32'd0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 16'hE000, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("post_rst_cnt4", 32'(txReady), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
